// File: rtl/field_serializer.sv
// Serializes a 5-bit word {a[2:0], b, c} as start, 5 data bits LSB first,
// optional parity and stop, each line bit held CLKS_PER_BIT clocks.
module field_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_active,
  output logic       frame_done,
  output logic [2:0] a_field,
  output logic       b_bit,
  output logic       c_bit,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic       ODD_BIT  = (ODD_PARITY != 0);

  state_t     state, state_next;
  logic [7:0] bit_cnt, bit_cnt_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [4:0] data_reg;
  logic       ser_next;
  logic       done_next;
  logic       accept;
  logic       last_cycle;
  logic       parity_bit;

  assign in_ready   = (state == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_cycle = (bit_cnt == LAST_CNT);
  assign parity_bit = (^data_reg) ^ ODD_BIT;
  assign ser_active = (state != IDLE);
  assign a_field    = data_reg[4:2];
  assign b_bit      = data_reg[1];
  assign c_bit      = data_reg[0];

  // ser_next is the level the line takes in the cycle after this edge, so the
  // registered ser_out lines up exactly with the state it belongs to.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next   = state;
    bit_cnt_next = bit_cnt + 8'd1;
    bit_idx_next = bit_idx;
    ser_next     = 1'b1;
    done_next    = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_next = 8'd0;
        if (accept) begin
          state_next = START;
          ser_next   = 1'b0;
        end
      end
      START: begin
        ser_next = 1'b0;
        if (last_cycle) begin
          state_next   = DATA;
          bit_cnt_next = 8'd0;
          bit_idx_next = 3'd0;
          ser_next     = data_reg[0];
        end
      end
      DATA: begin
        ser_next = data_reg[bit_idx];
        if (last_cycle) begin
          bit_cnt_next = 8'd0;
          if (bit_idx == 3'd4) begin
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              ser_next   = parity_bit;
            end else begin
              state_next = STOP;
              ser_next   = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            ser_next     = data_reg[bit_idx + 3'd1];
          end
        end
      end
      PARITY: begin
        ser_next = parity_bit;
        if (last_cycle) begin
          state_next   = STOP;
          bit_cnt_next = 8'd0;
          ser_next     = 1'b1;
        end
      end
      STOP: begin
        if (last_cycle) begin
          state_next   = IDLE;
          bit_cnt_next = 8'd0;
          done_next    = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 8'd0;
      bit_idx    <= 3'd0;
      data_reg   <= 5'd0;
      ser_out    <= 1'b1;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      ser_out    <= ser_next;
      frame_done <= done_next;
      if (accept)    data_reg  <= in_data;
      if (done_next) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
// Drives three serializer configurations with directed and random words and
// compares each frame against a bit-list model built from the frame rules.
module tb_field_serializer;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] ser_out;
  logic [2:0] ser_active;
  logic [2:0] frame_done;
  logic [4:0] in_data   [3];
  logic [2:0] a_field   [3];
  logic       b_bit     [3];
  logic       c_bit     [3];
  logic [7:0] frame_cnt [3];

  int tests = 0;
  int fails = 0;

  int cpb_cfg [3] = '{4, 1, 4};
  bit pen_cfg [3] = '{1'b1, 1'b1, 1'b0};
  bit odd_cfg [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] exp_cnt [3] = '{8'd0, 8'd0, 8'd0};

  field_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .ODD_PARITY(0)) u_def (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_active(ser_active[0]),
    .frame_done(frame_done[0]), .a_field(a_field[0]), .b_bit(b_bit[0]),
    .c_bit(c_bit[0]), .frame_cnt(frame_cnt[0]));

  field_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1), .ODD_PARITY(1)) u_fast_odd (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_active(ser_active[1]),
    .frame_done(frame_done[1]), .a_field(a_field[1]), .b_bit(b_bit[1]),
    .c_bit(c_bit[1]), .frame_cnt(frame_cnt[1]));

  field_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .ODD_PARITY(0)) u_nopar (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_active(ser_active[2]),
    .frame_done(frame_done[2]), .a_field(a_field[2]), .b_bit(b_bit[2]),
    .c_bit(c_bit[2]), .frame_cnt(frame_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level per cycle: list of bits from the frame rules, each repeated cpb times.
  function automatic logic [63:0] expected_line(input int k, input logic [4:0] w,
                                                output int len);
    bit          bits[$];
    logic [63:0] v = '0;
    bits.push_back(1'b0);
    for (int j = 0; j < 5; j++) bits.push_back(w[j]);
    if (pen_cfg[k]) bits.push_back(bit'($countones(w) % 2) ^ odd_cfg[k]);
    bits.push_back(1'b1);
    len = 0;
    foreach (bits[b])
      for (int r = 0; r < cpb_cfg[k]; r++) begin
        v[len] = bits[b];
        len++;
      end
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first
  // idle cycle after the frame. hold keeps in_valid high with next_w queued.
  task automatic send_frame(input int k, input logic [4:0] w, input bit hold,
                            input logic [4:0] next_w);
    logic [63:0] exp_line, obs_line, obs_act;
    int          len;
    bit          quiet_ok;
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    check($sformatf("in_ready_idle[%0d]", k), in_ready[k], 1);
    @(negedge clk);
    in_valid[k] = hold;
    in_data[k]  = hold ? next_w : 5'($urandom);
    exp_line = expected_line(k, w, len);
    obs_line = '0;
    obs_act  = '0;
    quiet_ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      obs_line[i] = ser_out[k];
      obs_act[i]  = ser_active[k];
      if ({a_field[k], b_bit[k], c_bit[k]} !== w || frame_done[k] !== 1'b0 ||
          in_ready[k] !== 1'b0)
        quiet_ok = 1'b0;
      if (!hold && i == len / 2) in_data[k] = ~w;
      @(negedge clk);
    end
    exp_cnt[k] = exp_cnt[k] + 8'd1;
    check($sformatf("line[%0d] w=%0h", k, w), obs_line, exp_line);
    check($sformatf("active[%0d]", k), obs_act, (64'd1 << len) - 64'd1);
    check($sformatf("fields_stable[%0d]", k), quiet_ok, 1);
    check($sformatf("frame_done[%0d]", k), frame_done[k], 1);
    check($sformatf("frame_cnt[%0d]", k), frame_cnt[k], exp_cnt[k]);
    check($sformatf("idle_line[%0d]", k), {ser_active[k], ser_out[k]}, 2'b01);
  endtask

  initial begin
    logic [4:0] words [257];
    bit         quiet;

    rst      = 3'b111;
    in_valid = 3'b000;
    for (int k = 0; k < 3; k++) in_data[k] = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_line", {ser_active[0], ser_out[0]}, 2'b01);
    check("reset_ready", in_ready[0], 0);
    check("reset_fields", {a_field[0], b_bit[0], c_bit[0]}, 5'd0);
    check("reset_cnt", frame_cnt[0], 0);
    check("reset_done", frame_done[0], 0);
    rst = 3'b000;
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 3'b111);
    @(negedge clk);

    // Default configuration, reference word.
    send_frame(0, 5'b10110, 1'b0, 5'd0);
    check("a_field_ref", a_field[0], 3'b101);
    check("b_bit_ref", b_bit[0], 1);
    check("c_bit_ref", c_bit[0], 0);
    check("cnt_ref", frame_cnt[0], 1);
    @(negedge clk);
    check("done_one_cycle", frame_done[0], 0);

    // in_valid held across two words: exactly one idle cycle between frames.
    send_frame(0, 5'h1F, 1'b1, 5'h01);
    send_frame(0, 5'h01, 1'b0, 5'd0);
    for (int n = 0; n < 4; n++) send_frame(0, 5'($urandom), 1'b0, 5'd0);

    // Reset in the middle of data bit 2.
    in_valid[0] = 1'b1;
    in_data[0]  = 5'($urandom);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_reset_active", ser_active[0], 1);
    rst[0] = 1'b1;
    #1;
    check("abort_line", {ser_active[0], ser_out[0]}, 2'b01);
    check("abort_ready", in_ready[0], 0);
    check("abort_cnt", frame_cnt[0], 0);
    check("abort_fields", {a_field[0], b_bit[0], c_bit[0]}, 5'd0);
    exp_cnt[0] = 8'd0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    check("ready_first_edge", in_ready[0], 1);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (frame_done[0] !== 1'b0 || ser_active[0] !== 1'b0) quiet = 1'b0;
    end
    check("no_done_after_abort", quiet, 1);
    check("cnt_after_abort", frame_cnt[0], 0);
    send_frame(0, 5'($urandom), 1'b0, 5'd0);

    // No parity: all-zero word, then random words.
    send_frame(2, 5'b00000, 1'b0, 5'd0);
    for (int n = 0; n < 3; n++) send_frame(2, 5'($urandom), 1'b0, 5'd0);

    // One clock per bit, odd parity, 256 back-to-back frames.
    words[0] = 5'b00000;
    for (int n = 1; n < 257; n++) words[n] = 5'($urandom);
    for (int n = 0; n < 256; n++) send_frame(1, words[n], n < 255, words[n + 1]);
    check("cnt_wrap", frame_cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
